// File: rtl/crossbar_2m2s_arb.sv
// ---------------------------------------------------------------------------
// crossbar_2m2s_arb
//
// Two-master / two-slave request-acknowledge crossbar. Each master's
// transaction is steered by address MSB (0 -> slave 1, 1 -> slave 2). Every
// slave has its own arbiter (IDLE / BUSY owned by M1 or M2) with a
// round-robin pointer that decides ties between simultaneous requesters.
// Grant and routing are combinational, so an idle slave sees a request in
// the same cycle the master raises it.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   master_{1,2}_req/cmd/addr/wdata    master request side (inputs)
//   master_{1,2}_ack/rdata             response routed back from the slave
//   slave_{1,2}_req/cmd/addr/wdata     forwarded request (zero when ungranted)
//   slave_{1,2}_ack/rdata              slave response (inputs)
// ---------------------------------------------------------------------------
module crossbar_2m2s_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              master_1_req,
  input  logic              master_1_cmd,
  input  logic [ADDR_W-1:0] master_1_addr,
  input  logic [DATA_W-1:0] master_1_wdata,
  output logic              master_1_ack,
  output logic [DATA_W-1:0] master_1_rdata,
  input  logic              master_2_req,
  input  logic              master_2_cmd,
  input  logic [ADDR_W-1:0] master_2_addr,
  input  logic [DATA_W-1:0] master_2_wdata,
  output logic              master_2_ack,
  output logic [DATA_W-1:0] master_2_rdata,
  output logic              slave_1_req,
  output logic              slave_1_cmd,
  output logic [ADDR_W-1:0] slave_1_addr,
  output logic [DATA_W-1:0] slave_1_wdata,
  input  logic              slave_1_ack,
  input  logic [DATA_W-1:0] slave_1_rdata,
  output logic              slave_2_req,
  output logic              slave_2_cmd,
  output logic [ADDR_W-1:0] slave_2_addr,
  output logic [DATA_W-1:0] slave_2_wdata,
  input  logic              slave_2_ack,
  input  logic [DATA_W-1:0] slave_2_rdata
);

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_M1 = 2'd1,
    ARB_BUSY_M2 = 2'd2
  } arb_state_t;

  arb_state_t s1_state_q, s1_state_d;
  arb_state_t s2_state_q, s2_state_d;
  // Round-robin pointer: 0 favours M1, 1 favours M2.
  logic       s1_ptr_q, s1_ptr_d;
  logic       s2_ptr_q, s2_ptr_d;

  logic       m1_sel, m2_sel;      // 1 = targets slave 2
  logic [1:0] s1_cand, s2_cand;    // bit0 = M1, bit1 = M2
  logic [1:0] s1_gnt, s2_gnt;      // one-hot or zero
  logic [2:0] s1_nxt, s2_nxt;

  // A locked arbiter keeps its owner; an idle one picks among candidates,
  // breaking a tie with the pointer.
  function automatic logic [1:0] arb_grant(arb_state_t st, logic [1:0] cand,
                                           logic ptr);
    logic [1:0] g;
    case (st)
      ARB_BUSY_M1: g = 2'b01;
      ARB_BUSY_M2: g = 2'b10;
      default: begin
        if (cand == 2'b11) g = ptr ? 2'b10 : 2'b01;
        else               g = cand;
      end
    endcase
    return g;
  endfunction

  // Returns {ptr_next, state_next}. Completion frees the slave and hands
  // priority to the other master; a pending request locks the owner; no
  // forwarded request (idle or owner abort) leaves the pointer untouched.
  function automatic logic [2:0] arb_next(logic [1:0] gnt, logic sreq,
                                          logic sack, logic ptr);
    logic [2:0] nxt;
    nxt = {ptr, ARB_IDLE};
    if (sreq && sack) nxt = {gnt[0], ARB_IDLE};
    else if (sreq)    nxt = {ptr, (gnt[0] ? ARB_BUSY_M1 : ARB_BUSY_M2)};
    return nxt;
  endfunction

  assign m1_sel = master_1_addr[ADDR_W-1];
  assign m2_sel = master_2_addr[ADDR_W-1];

  // A master locked on one slave is never offered to the other, so it holds
  // at most one grant even if its address moves mid-transaction.
  assign s1_cand = {master_2_req & ~m2_sel & (s2_state_q != ARB_BUSY_M2),
                    master_1_req & ~m1_sel & (s2_state_q != ARB_BUSY_M1)};
  assign s2_cand = {master_2_req &  m2_sel & (s1_state_q != ARB_BUSY_M2),
                    master_1_req &  m1_sel & (s1_state_q != ARB_BUSY_M1)};

  // Gating with rst_n forces every output to zero while reset is held.
  assign s1_gnt = rst_n ? arb_grant(s1_state_q, s1_cand, s1_ptr_q) : 2'b00;
  assign s2_gnt = rst_n ? arb_grant(s2_state_q, s2_cand, s2_ptr_q) : 2'b00;

  // Forward path: grants are one-hot, so AND-OR muxing yields zero when idle.
  assign slave_1_req   = (s1_gnt[0] & master_1_req) | (s1_gnt[1] & master_2_req);
  assign slave_1_cmd   = (s1_gnt[0] & master_1_cmd) | (s1_gnt[1] & master_2_cmd);
  assign slave_1_addr  = ({ADDR_W{s1_gnt[0]}} & master_1_addr)
                       | ({ADDR_W{s1_gnt[1]}} & master_2_addr);
  assign slave_1_wdata = ({DATA_W{s1_gnt[0]}} & master_1_wdata)
                       | ({DATA_W{s1_gnt[1]}} & master_2_wdata);

  assign slave_2_req   = (s2_gnt[0] & master_1_req) | (s2_gnt[1] & master_2_req);
  assign slave_2_cmd   = (s2_gnt[0] & master_1_cmd) | (s2_gnt[1] & master_2_cmd);
  assign slave_2_addr  = ({ADDR_W{s2_gnt[0]}} & master_1_addr)
                       | ({ADDR_W{s2_gnt[1]}} & master_2_addr);
  assign slave_2_wdata = ({DATA_W{s2_gnt[0]}} & master_1_wdata)
                       | ({DATA_W{s2_gnt[1]}} & master_2_wdata);

  // Return path: an ack from a slave not granted to this master is dropped.
  assign master_1_ack   = (s1_gnt[0] & slave_1_ack) | (s2_gnt[0] & slave_2_ack);
  assign master_1_rdata = ({DATA_W{s1_gnt[0]}} & slave_1_rdata)
                        | ({DATA_W{s2_gnt[0]}} & slave_2_rdata);
  assign master_2_ack   = (s1_gnt[1] & slave_1_ack) | (s2_gnt[1] & slave_2_ack);
  assign master_2_rdata = ({DATA_W{s1_gnt[1]}} & slave_1_rdata)
                        | ({DATA_W{s2_gnt[1]}} & slave_2_rdata);

  always_comb begin
    s1_nxt     = arb_next(s1_gnt, slave_1_req, slave_1_ack, s1_ptr_q);
    s2_nxt     = arb_next(s2_gnt, slave_2_req, slave_2_ack, s2_ptr_q);
    s1_ptr_d   = s1_nxt[2];
    s1_state_d = arb_state_t'(s1_nxt[1:0]);
    s2_ptr_d   = s2_nxt[2];
    s2_state_d = arb_state_t'(s2_nxt[1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_state_q <= ARB_IDLE;
      s2_state_q <= ARB_IDLE;
      s1_ptr_q   <= 1'b0;
      s2_ptr_q   <= 1'b0;
    end else begin
      s1_state_q <= s1_state_d;
      s2_state_q <= s2_state_d;
      s1_ptr_q   <= s1_ptr_d;
      s2_ptr_q   <= s2_ptr_d;
    end
  end

endmodule

// File: tb/tb_crossbar_2m2s_arb.sv
// ---------------------------------------------------------------------------
// tb_crossbar_2m2s_arb
//
// Directed bench for crossbar_2m2s_arb. Inputs change on the falling edge;
// combinational outputs are sampled 1 ns later, well clear of the rising edge
// where arbiter state updates.
// ---------------------------------------------------------------------------
module tb_crossbar_2m2s_arb;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              master_1_req, master_2_req;
  logic              master_1_cmd, master_2_cmd;
  logic [ADDR_W-1:0] master_1_addr, master_2_addr;
  logic [DATA_W-1:0] master_1_wdata, master_2_wdata;
  logic              master_1_ack, master_2_ack;
  logic [DATA_W-1:0] master_1_rdata, master_2_rdata;
  logic              slave_1_req, slave_2_req;
  logic              slave_1_cmd, slave_2_cmd;
  logic [ADDR_W-1:0] slave_1_addr, slave_2_addr;
  logic [DATA_W-1:0] slave_1_wdata, slave_2_wdata;
  logic              slave_1_ack, slave_2_ack;
  logic [DATA_W-1:0] slave_1_rdata, slave_2_rdata;

  int n_checks;
  int n_fail;

  crossbar_2m2s_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .master_1_req   (master_1_req),
    .master_1_cmd   (master_1_cmd),
    .master_1_addr  (master_1_addr),
    .master_1_wdata (master_1_wdata),
    .master_1_ack   (master_1_ack),
    .master_1_rdata (master_1_rdata),
    .master_2_req   (master_2_req),
    .master_2_cmd   (master_2_cmd),
    .master_2_addr  (master_2_addr),
    .master_2_wdata (master_2_wdata),
    .master_2_ack   (master_2_ack),
    .master_2_rdata (master_2_rdata),
    .slave_1_req    (slave_1_req),
    .slave_1_cmd    (slave_1_cmd),
    .slave_1_addr   (slave_1_addr),
    .slave_1_wdata  (slave_1_wdata),
    .slave_1_ack    (slave_1_ack),
    .slave_1_rdata  (slave_1_rdata),
    .slave_2_req    (slave_2_req),
    .slave_2_cmd    (slave_2_cmd),
    .slave_2_addr   (slave_2_addr),
    .slave_2_wdata  (slave_2_wdata),
    .slave_2_ack    (slave_2_ack),
    .slave_2_rdata  (slave_2_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act,
                          input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    master_1_req = 0; master_1_cmd = 0; master_1_addr = '0; master_1_wdata = '0;
    master_2_req = 0; master_2_cmd = 0; master_2_addr = '0; master_2_wdata = '0;
    slave_1_ack = 0; slave_1_rdata = '0;
    slave_2_ack = 0; slave_2_rdata = '0;
  endtask

  // One uncontended transaction from one master; the target slave follows
  // from addr[31], the other slave must stay fully quiet.
  task automatic single_xfer(input string tag, input bit from_m2, input logic cmd,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd);
    bit to_s2;
    to_s2 = a[31];
    @(negedge clk);
    if (!from_m2) begin
      master_1_req = 1; master_1_cmd = cmd; master_1_addr = a; master_1_wdata = wd;
    end else begin
      master_2_req = 1; master_2_cmd = cmd; master_2_addr = a; master_2_wdata = wd;
    end
    #1;
    if (!to_s2) begin
      check_eq({tag, "_s1_req"},   slave_1_req,   1);
      check_eq({tag, "_s1_cmd"},   slave_1_cmd,   cmd);
      check_eq({tag, "_s1_addr"},  slave_1_addr,  a);
      check_eq({tag, "_s1_wdata"}, slave_1_wdata, wd);
      check_eq({tag, "_s2_req"},   slave_2_req,   0);
      check_eq({tag, "_s2_addr"},  slave_2_addr,  0);
      check_eq({tag, "_s2_wdata"}, slave_2_wdata, 0);
    end else begin
      check_eq({tag, "_s2_req"},   slave_2_req,   1);
      check_eq({tag, "_s2_cmd"},   slave_2_cmd,   cmd);
      check_eq({tag, "_s2_addr"},  slave_2_addr,  a);
      check_eq({tag, "_s2_wdata"}, slave_2_wdata, wd);
      check_eq({tag, "_s1_req"},   slave_1_req,   0);
      check_eq({tag, "_s1_addr"},  slave_1_addr,  0);
      check_eq({tag, "_s1_wdata"}, slave_1_wdata, 0);
    end
    check_eq({tag, "_ack_wait"}, from_m2 ? master_2_ack : master_1_ack, 0);
    if (!to_s2) begin slave_1_ack = 1; slave_1_rdata = rd; end
    else        begin slave_2_ack = 1; slave_2_rdata = rd; end
    #1;
    check_eq({tag, "_ack"},   from_m2 ? master_2_ack   : master_1_ack,   1);
    check_eq({tag, "_rdata"}, from_m2 ? master_2_rdata : master_1_rdata, rd);
    check_eq({tag, "_other_ack"}, from_m2 ? master_1_ack : master_2_ack, 0);
    @(negedge clk);
    clear_inputs();
    #1;
    check_eq({tag, "_done_s1_req"}, slave_1_req, 0);
    check_eq({tag, "_done_s2_req"}, slave_2_req, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    rst_n = 0;
    // Activity during reset must not leak through.
    master_1_req = 1; master_1_cmd = 1; master_1_addr = 32'h7FFFFFFF;
    master_1_wdata = 32'h11111111; slave_1_ack = 1; slave_1_rdata = 32'h12345678;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_s1_req",   slave_1_req,    0);
    check_eq("rst_s1_addr",  slave_1_addr,   0);
    check_eq("rst_s1_wdata", slave_1_wdata,  0);
    check_eq("rst_m1_ack",   master_1_ack,   0);
    check_eq("rst_m1_rdata", master_1_rdata, 0);
    check_eq("rst_s2_req",   slave_2_req,    0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1;

    // Single writes and reads
    single_xfer("wr_m1_s1", 0, 1, 32'h7FFFFFFF, 32'h11111111, 32'h0000AAAA);
    single_xfer("wr_m1_s2", 0, 1, 32'hFFFFFFFF, 32'h22221111, 32'h0000BBBB);
    single_xfer("wr_m2_s1", 1, 1, 32'h7FFFFFFF, 32'h11112222, 32'h0000CCCC);
    single_xfer("wr_m2_s2", 1, 1, 32'hFFFFFFFF, 32'h22222222, 32'h0000DDDD);
    single_xfer("rd_m1_s1", 0, 0, 32'h7FFFFFFF, 32'h0,        32'h10000001);
    single_xfer("rd_m2_s2", 1, 0, 32'hFFFFFFFF, 32'h0,        32'h20000002);

    // Ack from the wrong slave is ignored
    @(negedge clk);
    master_1_req = 1; master_1_cmd = 0; master_1_addr = 32'hFFFFFFFF;
    #1;
    slave_1_ack = 1; slave_1_rdata = 32'hDEADBEEF;
    #1;
    check_eq("wrong_m1_ack",   master_1_ack,   0);
    check_eq("wrong_m1_rdata", master_1_rdata, 0);
    check_eq("wrong_s2_req",   slave_2_req,    1);
    @(negedge clk);
    slave_1_ack = 0;
    #1;
    check_eq("wrong_s2_req_held", slave_2_req, 1);
    check_eq("wrong_s1_req",      slave_1_req, 0);
    slave_2_ack = 1; slave_2_rdata = 32'h20000002;
    #1;
    check_eq("wrong_m1_ack_s2",   master_1_ack,   1);
    check_eq("wrong_m1_rdata_s2", master_1_rdata, 32'h20000002);
    @(negedge clk);
    clear_inputs();

    // Parallel: M1 -> S1 and M2 -> S2 in the same cycle
    @(negedge clk);
    master_1_req = 1; master_1_cmd = 1; master_1_addr = 32'h7FFFFFFF; master_1_wdata = 32'h11111111;
    master_2_req = 1; master_2_cmd = 1; master_2_addr = 32'hFFFFFFFF; master_2_wdata = 32'h22221111;
    #1;
    check_eq("par_s1_wdata", slave_1_wdata, 32'h11111111);
    check_eq("par_s2_wdata", slave_2_wdata, 32'h22221111);
    slave_1_ack = 1; slave_2_ack = 1;
    #1;
    check_eq("par_m1_ack", master_1_ack, 1);
    check_eq("par_m2_ack", master_2_ack, 1);
    @(negedge clk);
    clear_inputs();

    // Contention on S1 and round-robin, starting from a fresh reset
    @(negedge clk);
    rst_n = 0;
    #1;
    rst_n = 1;
    @(negedge clk);
    master_1_req = 1; master_1_cmd = 1; master_1_addr = 32'h7FFFFFFF; master_1_wdata = 32'h11111111;
    master_2_req = 1; master_2_cmd = 1; master_2_addr = 32'h1FFFFFFF; master_2_wdata = 32'h11112222;
    #1;
    check_eq("cont1_s1_wdata", slave_1_wdata, 32'h11111111);
    check_eq("cont1_m2_ack",   master_2_ack,  0);
    check_eq("cont1_s2_req",   slave_2_req,   0);
    @(negedge clk);
    #1;
    check_eq("cont1_locked_wdata", slave_1_wdata, 32'h11111111);
    slave_1_ack = 1;
    #1;
    check_eq("cont1_m1_ack", master_1_ack, 1);
    check_eq("cont1_m2_ack_held", master_2_ack, 0);
    @(negedge clk);
    // Both still requesting: the pointer now favours M2.
    slave_1_ack = 0;
    #1;
    check_eq("cont2_s1_wdata", slave_1_wdata, 32'h11112222);
    check_eq("cont2_s1_addr",  slave_1_addr,  32'h1FFFFFFF);
    slave_1_ack = 1;
    #1;
    check_eq("cont2_m2_ack", master_2_ack, 1);
    check_eq("cont2_m1_ack", master_1_ack, 0);
    @(negedge clk);
    slave_1_ack = 0;
    #1;
    check_eq("cont3_s1_wdata", slave_1_wdata, 32'h11111111);
    @(negedge clk);
    clear_inputs();

    // Reset asserted while S1 is locked
    @(negedge clk);
    master_1_req = 1; master_1_cmd = 1; master_1_addr = 32'h7FFFFFFF; master_1_wdata = 32'h11111111;
    @(negedge clk);
    #1;
    check_eq("rstmid_pre_s1_req", slave_1_req, 1);
    rst_n = 0;
    slave_1_ack = 1; slave_1_rdata = 32'h55555555;
    #1;
    check_eq("rstmid_s1_req",   slave_1_req,    0);
    check_eq("rstmid_s1_wdata", slave_1_wdata,  0);
    check_eq("rstmid_m1_ack",   master_1_ack,   0);
    check_eq("rstmid_m1_rdata", master_1_rdata, 0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    #1;
    check_eq("rstmid_after_s1_req", slave_1_req, 0);

    // Abort: owner drops req before ack, the waiting master takes over
    @(negedge clk);
    master_1_req = 1; master_1_cmd = 1; master_1_addr = 32'h7FFFFFFF; master_1_wdata = 32'h11111111;
    master_2_req = 1; master_2_cmd = 1; master_2_addr = 32'h1FFFFFFF; master_2_wdata = 32'h11112222;
    #1;
    check_eq("abort_s1_wdata", slave_1_wdata, 32'h11111111);
    @(negedge clk);
    master_1_req = 0;
    #1;
    check_eq("abort_s1_req_drop", slave_1_req,  0);
    check_eq("abort_m2_ack",      master_2_ack, 0);
    @(negedge clk);
    #1;
    check_eq("abort_m2_s1_req",   slave_1_req,   1);
    check_eq("abort_m2_s1_wdata", slave_1_wdata, 32'h11112222);
    slave_1_ack = 1;
    #1;
    check_eq("abort_m2_ack_done", master_2_ack, 1);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crossbar_2m2s_arb.md
Name: crossbar_2m2s_arb

Overview:
Two-master, two-slave request/acknowledge bus crossbar with per-slave round-robin arbitration. Each master transaction is routed to a slave by address bit 31. When both masters target the same slave, an arbiter grants one master and holds it until the slave acknowledges. It sits between two bus initiators (e.g. CPU cores) and two memory-mapped targets.

Parameters:
ADDR_W, 32, address width; the MSB selects the slave.
DATA_W, 32, width of the write-data and read-data buses.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
master_1_req, master_2_req  in  1  master request; held high until ack is returned.
master_1_cmd, master_2_cmd  in  1  1 = write, 0 = read.
master_1_addr, master_2_addr  in  ADDR_W  transaction address.
master_1_wdata, master_2_wdata  in  DATA_W  write data.
master_1_ack, master_2_ack  out  1  acknowledge routed back from the granted slave.
master_1_rdata, master_2_rdata  out  DATA_W  read data routed back from the granted slave.
slave_1_req, slave_2_req  out  1  request to the slave.
slave_1_cmd, slave_2_cmd  out  1  forwarded cmd.
slave_1_addr, slave_2_addr  out  ADDR_W  forwarded address, unmodified (all bits).
slave_1_wdata, slave_2_wdata  out  DATA_W  forwarded write data.
slave_1_ack, slave_2_ack  in  1  slave acknowledge.
slave_1_rdata, slave_2_rdata  in  DATA_W  slave read data.

Behaviour:
- Decode: addr[ADDR_W-1]=0 targets slave 1; =1 targets slave 2. Example: 0x7FFFFFFF and 0x1FFFFFFF go to S1; 0xFFFFFFFF goes to S2.
- Per-slave arbiter state: IDLE, or BUSY with an owner (M1/M2). Each arbiter also keeps a round-robin priority pointer.
- Reset (rst_n low, asynchronous): both arbiters go to IDLE and the pointer favours M1.
- Outputs during reset and whenever a slave is ungranted: slave req/cmd/addr/wdata = 0; the corresponding master ack = 0 and rdata = 0.
- IDLE grant is combinational, with zero latency:
  - one requester targeting the slave is granted immediately;
  - two requesters: the pointer's favoured master is granted.
- Granted path is purely combinational:
  - slave_x_req/cmd/addr/wdata = the owner's signals;
  - master ack = the granted slave's ack;
  - master rdata = the granted slave's rdata.
- A master is granted to at most one slave at a time, namely the slave its address decodes to.
- Completion: at a rising clk edge with slave_req=1 and slave_ack=1, the transaction completes. The arbiter returns to IDLE and the pointer moves to favour the other master.
- Lock: at a rising edge with slave_req=1 and slave_ack=0, the arbiter enters (or stays) BUSY with that owner. While BUSY, only the owner is routed, regardless of the other master's requests or address changes.
- Abort: if the owner drops req before ack, the arbiter returns to IDLE at the next edge. The pointer is not advanced.
- The losing master sees ack=0 and must keep req high. It is granted once the slave frees up, starting in the same cycle the arbiter is IDLE.
- Different slaves proceed fully in parallel (M1→S1 concurrently with M2→S2, and vice versa).
- A slave ack arriving while that slave is ungranted is ignored: no master ack and no state change.
- cmd does not affect routing; the rdata path is active for both reads and writes.
- Reset asserted mid-transaction: outputs drop to 0 immediately and all grants are lost.

Test Plan:
- Single writes, one per case: M1 writes 0x7FFFFFFF/0x11111111, then 0xFFFFFFFF/0x22221111; M2 writes 0x7FFFFFFF/0x11112222, then 0xFFFFFFFF/0x22222222. Required: the correct slave_x_req=1 with addr/wdata/cmd=1 forwarded; the master ack mirrors slave ack; the other slave's outputs stay 0.
- Reads: M1 reads 0x7FFFFFFF with S1 rdata=0x10000001 and S1 ack → master_1_rdata=0x10000001, master_1_ack=1. M2 reads 0xFFFFFFFF with S2 rdata=0x20000002 → master_2_rdata=0x20000002.
- Wrong-slave ack: M1 reads 0xFFFFFFFF while only slave_1_ack pulses → master_1_ack stays 0, and slave_2_req stays 1 until slave_2_ack.
- Parallel: M1 writes to 0x7FFFFFFF and M2 writes to 0xFFFFFFFF simultaneously, both slaves ack → both masters acked in the same cycle; S1 sees 0x11111111 and S2 sees 0x22221111.
- Contention and round-robin: both masters write S1 (0x7FFFFFFF, 0x1FFFFFFF) after reset. Required: M1 is granted first (S1 wdata=0x11111111) and M2 is held with ack=0. After S1 acks, M2 is granted (wdata=0x11112222). On the next contention round, M2 wins first.
- Reset/abort: assert rst_n=0 while BUSY → all outputs 0 immediately. Owner drops req without ack → the arbiter frees, and the other master is granted next cycle.
